// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: run/irq controls and registered raster outputs of vga_timing_gen.
interface vga_timing_gen_if #(
    parameter int CW = 10
);
    logic          EN;
    logic          IRQ_CLR;
    logic          H_SYNC;
    logic          V_SYNC;
    logic          VALID;
    logic [CW-1:0] X;
    logic [CW-1:0] Y;
    logic [CW-1:0] H_CNT;
    logic [CW-1:0] V_CNT;
    logic          LINE_START;
    logic          FRAME_START;
    logic [15:0]   FRAME_CNT;
    logic          BUSY;
    logic          VBLANK_IRQ;

    modport master (
        input  EN, IRQ_CLR,
        output H_SYNC, V_SYNC, VALID, X, Y, H_CNT, V_CNT,
               LINE_START, FRAME_START, FRAME_CNT, BUSY, VBLANK_IRQ
    );

    modport slave (
        output EN, IRQ_CLR,
        input  H_SYNC, V_SYNC, VALID, X, Y, H_CNT, V_CNT,
               LINE_START, FRAME_START, FRAME_CNT, BUSY, VBLANK_IRQ
    );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing with run/drain control and frame counter.
// Define VGA_TIMING_IRQ_EN to enable the sticky vertical-blank interrupt flag.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int LEAD     = 1,
    parameter int CW       = 10
) (
    input logic               CLK,
    input logic               RST_N,
    vga_timing_gen_if.master  b
);
    localparam int H_TOTAL  = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL  = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int HA_START = H_SYNC + H_BP;
    localparam int VA_START = V_SYNC + V_BP;

    localparam logic [CW-1:0] H_LAST  = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST  = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] HS_END  = CW'(H_SYNC);
    localparam logic [CW-1:0] VS_END  = CW'(V_SYNC);
    localparam logic [CW-1:0] HV_BEG  = CW'(HA_START - LEAD);
    localparam logic [CW-1:0] HV_END  = CW'(HA_START + H_ACTIVE - 1 - LEAD);
    localparam logic [CW-1:0] VV_BEG  = CW'(VA_START);
    localparam logic [CW-1:0] VV_END  = CW'(VA_START + V_ACTIVE - 1);
    localparam logic [CW-1:0] VB_LINE = CW'(VA_START + V_ACTIVE);

    if (LEAD < 0 || LEAD > 2 || LEAD > HA_START || H_TOTAL > (1 << CW) || V_TOTAL > (1 << CW)) begin : g_bad_cfg
        $error("vga_timing_gen: LEAD must be 0..2 and <= HA_START, and CW must cover the totals");
    end

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t        st, st_nx;
    logic [CW-1:0] hc, vc, hc_nx, vc_nx;
    logic          adv, h_last, v_last, valid_nx, fs_nx;

    // hc/vc point at the raster position the output registers load on the next edge,
    // so every registered output lines up with H_CNT/V_CNT in the same cycle.
    always_comb begin
        adv      = st != IDLE;
        h_last   = hc == H_LAST;
        v_last   = vc == V_LAST;
        st_nx    = st == IDLE ? (b.EN ? RUN : IDLE) :
                   b.EN ? RUN : (st == DRAIN && h_last && v_last) ? IDLE : DRAIN;
        hc_nx    = (!adv || h_last) ? '0 : hc + 1'b1;
        vc_nx    = (!adv || (h_last && v_last)) ? '0 : h_last ? vc + 1'b1 : vc;
        valid_nx = adv && vc >= VV_BEG && vc <= VV_END && hc >= HV_BEG && hc <= HV_END;
        fs_nx    = adv && hc == '0 && vc == '0;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            st <= IDLE;
            hc <= '0;
            vc <= '0;
        end else begin
            st <= st_nx;
            hc <= hc_nx;
            vc <= vc_nx;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            b.H_CNT       <= '0;
            b.V_CNT       <= '0;
            b.H_SYNC      <= ~HS_POL;
            b.V_SYNC      <= ~VS_POL;
            b.VALID       <= 1'b0;
            b.X           <= '0;
            b.Y           <= '0;
            b.LINE_START  <= 1'b0;
            b.FRAME_START <= 1'b0;
            b.FRAME_CNT   <= '0;
            b.BUSY        <= 1'b0;
        end else begin
            b.H_CNT       <= adv ? hc : '0;
            b.V_CNT       <= adv ? vc : '0;
            b.H_SYNC      <= (adv && hc < HS_END) ? HS_POL : ~HS_POL;
            b.V_SYNC      <= (adv && vc < VS_END) ? VS_POL : ~VS_POL;
            b.VALID       <= valid_nx;
            b.X           <= valid_nx ? hc - HV_BEG : '0;
            b.Y           <= valid_nx ? vc - VV_BEG : '0;
            b.LINE_START  <= adv && hc == '0;
            b.FRAME_START <= fs_nx;
            b.FRAME_CNT   <= b.FRAME_CNT + {15'd0, fs_nx};
            b.BUSY        <= adv;
        end
    end

`ifdef VGA_TIMING_IRQ_EN
    // A set in the same cycle as IRQ_CLR takes priority so no blanking event is lost.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            b.VBLANK_IRQ <= 1'b0;
        else if (adv && hc == '0 && vc == VB_LINE)
            b.VBLANK_IRQ <= 1'b1;
        else if (b.IRQ_CLR)
            b.VBLANK_IRQ <= 1'b0;
    end
`else
    logic unused_irq;
    assign unused_irq   = b.IRQ_CLR ^ (VB_LINE == '0);
    assign b.VBLANK_IRQ = 1'b0;
`endif
endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator, the successor to the fixed 640x480 scan counter. Generates horizontal and vertical sync, an active-video qualifier, and active-area-relative pixel coordinates for any mode set by parameters. Adds programmable sync polarity, a programmable VALID lead for pipelined pixel sources, run/stop control that stops only on frame boundaries, line/frame strobes, and a frame counter. Sits between the pixel clock domain root and the framebuffer/sprite pixel pipeline.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, horizontal sync width (clocks)
- H_BP, 48, horizontal back porch (clocks)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, level of H_SYNC during its pulse (0 = active-low)
- VS_POL, 0, level of V_SYNC during its pulse
- LEAD, 1, cycles VALID/X/Y lead the raster (0..2)
- CW, 10, counter/coordinate width; 2^CW ≥ H_TOTAL and ≥ V_TOTAL

- CLK  in  1  pixel clock, rising edge
- RST_N  in  1  asynchronous active-low reset
- EN  in  1  run request
- IRQ_CLR  in  1  clears VBLANK_IRQ
- H_SYNC  out  1  horizontal sync
- V_SYNC  out  1  vertical sync
- VALID  out  1  active-area qualifier, LEAD cycles early
- X  out  CW  active-relative column, valid with VALID
- Y  out  CW  active-relative row, valid with VALID
- H_CNT  out  CW  raw horizontal count
- V_CNT  out  CW  raw vertical count
- LINE_START  out  1  one-cycle pulse at H_CNT=0 while running
- FRAME_START  out  1  one-cycle pulse at H_CNT=0,V_CNT=0 while running
- FRAME_CNT  out  16  frames started, wraps
- BUSY  out  1  generator not IDLE
- VBLANK_IRQ  out  1  sticky vertical-blank flag

## Operation
- Derived: H_TOTAL=H_SYNC+H_BP+H_ACTIVE+H_FP; HA_START=H_SYNC+H_BP; V_TOTAL, VA_START likewise. Line order: sync, back porch, active, front porch.
- States: IDLE, RUN, DRAIN. IDLE: counters held 0, syncs at inactive level, all pulses 0. IDLE & EN=1 → RUN. RUN & EN=0 → DRAIN. DRAIN & EN=1 → RUN (no gap). DRAIN at H_CNT=H_TOTAL-1, V_CNT=V_TOTAL-1 → IDLE. RUN never stops mid-frame.
- H_CNT counts 0..H_TOTAL-1 then wraps; V_CNT increments on H wrap, wraps after V_TOTAL-1.
- Sync pulse active when H_CNT<H_SYNC (resp. V_CNT<V_SYNC); output = POL when active, ~POL otherwise.
- VALID=1 when V_CNT in [VA_START, VA_START+V_ACTIVE-1] and H_CNT in [HA_START-LEAD, HA_START+H_ACTIVE-1-LEAD]. X=H_CNT+LEAD-HA_START, Y=V_CNT-VA_START while VALID; both 0 otherwise.
- FRAME_CNT increments with each FRAME_START, wraps 0xFFFF→0.
- All outputs registered; H_SYNC, V_SYNC, VALID, X, Y, pulses computed from next-state counters so they align with H_CNT/V_CNT in the same cycle.

## Timing
- Reset: H_CNT=0, V_CNT=0, H_SYNC=~HS_POL, V_SYNC=~VS_POL, VALID=0, X=0, Y=0, LINE_START=0, FRAME_START=0, FRAME_CNT=0, BUSY=0, VBLANK_IRQ=0, state IDLE. Reset mid-frame aborts immediately.
- EN sampled high in IDLE at edge k: after edge k+1 BUSY=1, H_CNT=0, V_CNT=0, FRAME_START=LINE_START=1, both syncs active, FRAME_CNT incremented.
- Final frame: last RUN cycle has H_CNT=H_TOTAL-1, V_CNT=V_TOTAL-1; next cycle is IDLE outputs.
- LEAD must be ≤ HA_START; elaboration fails otherwise.

## Configuration
- VGA_TIMING_IRQ_EN defined: VBLANK_IRQ sets the cycle H_CNT=0, V_CNT=VA_START+V_ACTIVE while running; cleared by IRQ_CLR=1 on next edge; simultaneous set and clear → set wins.
- Undefined: VBLANK_IRQ tied 0, IRQ_CLR ignored; port list unchanged.

## Test plan
- Reset then EN=1 (defaults): first run cycle H_CNT=0,V_CNT=0, FRAME_START=1, H_SYNC=0, V_SYNC=0; H_SYNC returns 1 at H_CNT=96; V_SYNC returns 1 at V_CNT=2.
- LEAD=1 defaults: VALID first rises at V_CNT=35,H_CNT=143 with X=0,Y=0; last high at V_CNT=514,H_CNT=782 with X=639,Y=479; 307200 VALID cycles per frame.
- Wrap: H_CNT 799→0 increments V_CNT with LINE_START=1; V_CNT 524→0 with FRAME_START=1, FRAME_CNT+1.
- EN dropped at V_CNT=100: raster continues to H=799,V=524, then BUSY=0 and counters 0; EN re-asserted at V_CNT=300 instead → frames continue uninterrupted.
- HS_POL=1, VS_POL=1, LEAD=0: sync pulses high, idle low; VALID first at H_CNT=144.
- With VGA_TIMING_IRQ_EN: VBLANK_IRQ sets at V_CNT=515,H_CNT=0; IRQ_CLR pulse clears it; IRQ_CLR held on set cycle → stays 1. RST_N low mid-frame → all outputs to reset values asynchronously.
